// File: rtl/obstacle_engine.sv
// obstacle_engine: multi-bar vertical obstacle mover with shadow config, wrap-around and run/pause control
module obstacle_engine #(
  parameter int NUM_BARS = 8,
  parameter int POS_W = 10,
  parameter int SCREEN_H = 480,
  parameter int SPD_W = 6
) (
  input  logic                      clkenv,
  input  logic                      rst,
  input  logic                      step_en,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic [1:0]                speed_shift,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_bar,
  input  logic [POS_W-1:0]          cfg_pos,
  input  logic [POS_W-1:0]          cfg_open,
  input  logic [SPD_W-1:0]          cfg_speed,
  output logic [NUM_BARS*POS_W-1:0] bar_pos,
  output logic [NUM_BARS*POS_W-1:0] bar_open,
  output logic [NUM_BARS-1:0]       wrap,
  output logic [1:0]                state_o
);
  localparam int W = POS_W + SPD_W + 4;
  localparam logic [POS_W-1:0] H = POS_W'(SCREEN_H);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, PAUSED = 2'd3;
  logic [1:0] state, nxt_state;
  logic move;
  always_comb begin
    nxt_state = (stop && state != IDLE) ? IDLE :
                (start && state != LOAD) ? LOAD :
                (state == LOAD) ? RUN :
                (state == RUN && pause) ? PAUSED :
                (state == PAUSED && !pause) ? RUN : state;
  end
  always_ff @(posedge clkenv) begin
    if (rst) state <= IDLE;
    else state <= nxt_state;
  end
  assign move = state == RUN && step_en && !pause && !stop && !start;
  assign state_o = state;
  for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
    logic [POS_W-1:0] sh_pos, sh_open, pos_q, open_q, mv_pos;
    logic [SPD_W-1:0] sh_spd, spd_q;
    logic signed [W-1:0] eff, nxt, lim;
    logic wrap_q, lo, hi;
    assign eff = $signed({{(W-SPD_W){spd_q[SPD_W-1]}}, spd_q}) <<< speed_shift;
    assign nxt = $signed({{(W-POS_W){1'b0}}, pos_q}) + eff;
    // an opening taller than the screen pins the bar to the top
    assign lim = open_q >= H ? '0 : $signed({{(W-POS_W){1'b0}}, H - open_q});
    assign lo = nxt < 0;
    assign hi = nxt > lim;
    assign mv_pos = lo ? lim[POS_W-1:0] : hi ? '0 : nxt[POS_W-1:0];
    always_ff @(posedge clkenv) begin
      if (rst) begin
        {sh_pos, sh_open, sh_spd} <= '0;
        {pos_q, open_q, spd_q} <= '0;
        wrap_q <= 1'b0;
      end else begin
        if (cfg_we && cfg_bar == 4'(g)) {sh_pos, sh_open, sh_spd} <= {cfg_pos, cfg_open, cfg_speed};
        if (state == LOAD) {pos_q, open_q, spd_q} <= {sh_pos, sh_open, sh_spd};
        else if (move && spd_q != '0) pos_q <= mv_pos;
        wrap_q <= move && spd_q != '0 && (lo || hi);
      end
    end
    assign bar_pos[g*POS_W +: POS_W] = pos_q;
    assign bar_open[g*POS_W +: POS_W] = open_q;
    assign wrap[g] = wrap_q;
  end
endmodule

// File: doc/obstacle_engine.md
OBSTACLE_ENGINE -- requirements
Module: obstacle_engine

Interface
REQ-001 Parameter NUM_BARS, default 8, number of independent bar channels (1..16).
REQ-002 Parameter POS_W, default 10, width of position and opening values.
REQ-003 Parameter SCREEN_H, default 480, playfield height in pixels; must be < 2^POS_W.
REQ-004 Parameter SPD_W, default 6, width of the signed per-bar speed (two's complement).
REQ-005 Port clkenv  in  1  sole clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port step_en  in  1  one-cycle motion strobe (frame tick); a move is applied only on cycles where it is high.
REQ-008 Port start  in  1  pulse; copies shadow config to active bars and begins motion.
REQ-009 Port stop  in  1  pulse; returns to IDLE and freezes outputs.
REQ-010 Port pause  in  1  level; while high in RUN, motion is suspended.
REQ-011 Port speed_shift  in  2  level-difficulty multiplier; effective speed = speed <<< speed_shift (arithmetic).
REQ-012 Port cfg_we  in  1  shadow-config write strobe.
REQ-013 Port cfg_bar  in  4  bar index for the write; indices >= NUM_BARS are ignored.
REQ-014 Port cfg_pos  in  POS_W  start position (top of opening) written to shadow.
REQ-015 Port cfg_open  in  POS_W  opening height written to shadow.
REQ-016 Port cfg_speed  in  SPD_W  signed speed written to shadow.
REQ-017 Port bar_pos  out  NUM_BARS*POS_W  active positions; bar i in bits [i*POS_W +: POS_W].
REQ-018 Port bar_open  out  NUM_BARS*POS_W  active openings, same packing.
REQ-019 Port wrap  out  NUM_BARS  one-cycle pulse per bar that wrapped on the last move.
REQ-020 Port state_o  out  2  current state: 0 IDLE, 1 LOAD, 2 RUN, 3 PAUSED.

Function
REQ-021 States IDLE, LOAD, RUN, PAUSED; one-hot or binary encoding is free, state_o encoding is fixed.
REQ-022 IDLE: start -> LOAD; all other inputs except cfg_we have no effect.
REQ-023 LOAD lasts exactly one cycle: every active bar takes shadow pos/open/speed; next state RUN; step_en in LOAD is ignored.
REQ-024 RUN: pause high -> PAUSED next cycle; step_en on the same cycle as pause rising is ignored.
REQ-025 PAUSED: pause low -> RUN; no motion, outputs hold.
REQ-026 stop in LOAD, RUN or PAUSED -> IDLE next cycle, outputs hold last values; stop wins over start and pause.
REQ-027 start in RUN or PAUSED -> LOAD (restart with current shadow config).
REQ-028 Move (RUN, step_en=1, no pause/stop/start): per bar, next = pos + (speed <<< speed_shift) computed signed in POS_W+SPD_W+4 bits; result registered, visible on bar_pos the cycle after step_en.
REQ-029 Limit L_i = SCREEN_H - open_i; if open_i >= SCREEN_H then L_i = 0.
REQ-030 Wrap: next < 0 -> pos = L_i; next > L_i -> pos = 0; else pos = next; wrap[i] pulses high exactly on the cycle pos updates via wrap.
REQ-031 next == 0 or next == L_i is in range; no wrap pulse.
REQ-032 Speed 0 bars never move nor wrap.
REQ-033 cfg_we in any state writes shadow only; active bars change only in LOAD; cfg_we and LOAD in same cycle: LOAD copies pre-write shadow.
REQ-034 bar_open output always equals active opening; unchanged by moves.

Reset
REQ-035 rst high at any clock edge, including mid-LOAD or mid-move: state IDLE, all shadow and active pos/open/speed = 0, wrap = 0, state_o = 0.
REQ-036 rst has priority over every other input in the same cycle.

Verification
REQ-037 Bar0 cfg pos=240 open=60 speed=-10, start, 3 step_en -> state_o 1 then 2; bar_pos0 = 230, 220, 210 each one cycle after step_en.
REQ-038 Bar1 pos=415 open=60 speed=+10 (L=420), 2 steps -> 0 then 10; wrap[1] high one cycle on first step only; bar pos=5 speed=-10 step -> 420, wrap pulse.
REQ-039 speed_shift=2, speed=+3, pos=100 -> step gives 112; speed=-3 -> 88.
REQ-040 RUN, pause=1 with 5 step_en -> positions frozen, state_o=3; pause=0, one step -> single move applied.
REQ-041 cfg_we bar2 pos=50 during RUN -> bar_pos2 unchanged; start -> after LOAD bar_pos2 = 50; cfg_bar=15 with NUM_BARS=8 -> no change anywhere.
REQ-042 rst asserted in LOAD cycle and simultaneously with stop+start -> next cycle state_o=0, all bar_pos/bar_open/wrap zero.
